noc_link_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one outgoing 16-bit router link in the 4x4 torus NoC.
- Shares the link between N requesters: Right, Left, Up and Down input ports plus local injection.
- Drives the link with the existing req/en/ans handshake.
- Returns a per-requester acceptance pulse and guards against a stalled downstream node with a timeout.

---
 rtl/noc_pkg.sv | 19 +
 rtl/rr_pick.sv | 27 ++
 rtl/noc_link_arbiter.sv | 108 ++++++++++
 tb/tb_noc_link_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit width, requester (port) indices and
// the link arbiter state encoding.
package noc_pkg;

  localparam int PKT_W = 16;

  localparam int DIR_R     = 0;
  localparam int DIR_L     = 1;
  localparam int DIR_U     = 2;
  localparam int DIR_D     = 3;
  localparam int DIR_LOCAL = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit scanning ptr+1,
// ptr+2, ... modulo N. Shared by every router output port arbiter.
module rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    winner  = '0;
    any_req = |req;
    // Scan from the farthest offset down to the nearest; the last hit is the
    // closest requester after ptr, so no early exit is needed.
    for (int off = N; off >= 1; off--) begin
      idx = (int'(ptr) + off) % N;
      if (req[idx]) winner = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/noc_link_arbiter.sv
// Round-robin arbiter/sequencer for one outgoing torus link (req/en/ans).
// Optional per-requester delivery counters: define NOC_LINK_ARB_STATS_EN.
module noc_link_arbiter
  import noc_pkg::*;
#(
  parameter int N       = 5,
  parameter int W       = PKT_W,
  parameter int TIMEOUT = 12,
  parameter int TO_W    = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_in,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   ans_out,
  output logic           link_req,
  output logic           link_en,
  output logic [W-1:0]   link_data,
  input  logic           link_ans,
  output logic           busy,
  output logic           timeout_err
`ifdef NOC_LINK_ARB_STATS_EN
  ,
  output logic [N*8-1:0] grant_cnt
`endif
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [TO_W-1:0]  cnt;
  logic [IDX_W-1:0] winner;
  logic             any_req;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req     (req_in),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign link_en = link_req;
  assign busy    = (state != IDLE);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= IDX_W'(N - 1);
      win         <= '0;
      cnt         <= '0;
      link_req    <= 1'b0;
      link_data   <= '0;
      ans_out     <= '0;
      timeout_err <= 1'b0;
    end else begin
      ans_out     <= '0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            win       <= winner;
            link_data <= data_in[int'(winner)*W +: W];
            cnt       <= '0;
            link_req  <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Acceptance beats the timeout when both land on the same cycle.
          if (link_ans) begin
            ans_out   <= N'(1) << win;
            ptr       <= win;
            link_req  <= 1'b0;
            link_data <= '0;
            state     <= RELEASE;
          end else if (cnt == TO_W'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            ptr         <= win;
            link_req    <= 1'b0;
            link_data   <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NOC_LINK_ARB_STATS_EN
  // Counters step on the same edge that raises ans_out, saturating at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt <= '0;
    end else if (state == SEND && link_ans &&
                 grant_cnt[int'(win)*8 +: 8] != 8'hFF) begin
      grant_cnt[int'(win)*8 +: 8] <= grant_cnt[int'(win)*8 +: 8] + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Scoreboard bench for noc_link_arbiter: expected grants are queued as
// requests are raised and retired against each ans_out pulse.
`timescale 1ns/1ps
module tb_noc_link_arbiter;
  import noc_pkg::*;

  localparam int N = 5;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_in = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   ans_out;
  logic           link_req;
  logic           link_en;
  logic [W-1:0]   link_data;
  logic           link_ans = 1'b0;
  logic           busy;
  logic           timeout_err;
`ifdef NOC_LINK_ARB_STATS_EN
  logic [N*8-1:0] grant_cnt;
`endif

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_timeouts = 0;
  bit   resp_en = 1'b0;
  int   ans_delay = 0;

  noc_link_arbiter #(.N(N), .W(W), .TIMEOUT(12), .TO_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_in      (req_in),
    .data_in     (data_in),
    .ans_out     (ans_out),
    .link_req    (link_req),
    .link_en     (link_en),
    .link_data   (link_data),
    .link_ans    (link_ans),
    .busy        (busy),
    .timeout_err (timeout_err)
`ifdef NOC_LINK_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_data(input int i, input logic [W-1:0] d);
    data_in[i*W +: W] = d;
  endtask

  task automatic push_exp(input int i, input logic [W-1:0] d);
    exp_t e;
    e.idx  = i;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_ans(input string tag, input int max);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (ans_out != '0) return;
    end
    check(tag, 32'(|ans_out), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Downstream node: raises link_ans ans_delay cycles into each SEND.
  initial begin
    int seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (resp_en && link_req) begin
        link_ans = (seen >= ans_delay);
        seen++;
      end else begin
        link_ans = 1'b0;
        seen     = 0;
      end
    end
  end

  // Monitor: link_data hold, ans/err exclusivity, scoreboard retirement.
  initial begin
    logic         prev_req;
    logic [W-1:0] prev_data;
    exp_t         e;
    prev_req  = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_req = 1'b0;
      end else begin
        if (link_req && prev_req) check("link_data_hold", 32'(link_data), 32'(prev_data));
        if (timeout_err) begin
          n_timeouts++;
          check("ans_with_err", 32'(ans_out), 0);
        end
        if (ans_out != '0) begin
          check("ans_onehot", 32'($onehot(ans_out)), 1);
          if (sb.size() == 0) begin
            check("ans_unexpected", 32'(ans_out), 0);
          end else begin
            e = sb.pop_front();
            check("ans_idx", 32'(ans_out), 32'(1) << e.idx);
            check("ans_data", 32'(prev_data), 32'(e.data));
          end
        end
        prev_req  = link_req;
        prev_data = link_data;
      end
    end
  end

  initial begin
    int t0, last, sends;

    // Reset state
    @(negedge clk);
    check("rst_link_req", 32'(link_req), 0);
    check("rst_link_en", 32'(link_en), 0);
    check("rst_link_data", 32'(link_data), 0);
    check("rst_ans_out", 32'(ans_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    @(negedge clk);
    reset = 1'b1;

    // Single packet from Up, accepted two cycles after link_req rises
    resp_en   = 1'b1;
    ans_delay = 2;
    @(negedge clk);
    set_data(DIR_U, 16'hA5A5);
    req_in = 5'b00100;
    push_exp(DIR_U, 16'hA5A5);
    t0 = cyc;
    @(negedge clk);
    check("t1_link_req", 32'(link_req), 1);
    check("t1_link_en", 32'(link_en), 1);
    check("t1_link_data", 32'(link_data), 32'hA5A5);
    check("t1_busy", 32'(busy), 1);
    wait_ans("t1_wait", 10);
    check("t1_latency", 32'(cyc - t0), 4);
    check("t1_busy_release", 32'(busy), 1);
    req_in = '0;
    @(negedge clk);
    check("t1_ans_one_cycle", 32'(ans_out), 0);
    check("t1_busy_low", 32'(busy), 0);

    // All requesters, immediate acceptance: rotation 0..4,0 every 3 cycles
    do_reset();
    ans_delay = 0;
    for (int i = 0; i < N; i++) set_data(i, 16'h1000 + 16'(i));
    for (int k = 0; k < 6; k++) push_exp(k % N, 16'h1000 + 16'(k % N));
    req_in = '1;
    last = 0;
    for (int k = 0; k < 6; k++) begin
      wait_ans("rr_wait", 10);
      if (k > 0) check("rr_gap", 32'(cyc - last), 3);
      last = cyc;
    end
    req_in = '0;
    @(negedge clk);
    @(negedge clk);
    check("rr_idle", 32'(busy), 0);

    // Stalled downstream: timeout after 12 SEND cycles, then re-grant
    resp_en = 1'b0;
    set_data(DIR_R, 16'h0C0C);
    req_in = 5'b00001;
    sends  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (timeout_err) break;
      if (link_req) sends++;
    end
    check("to_seen", 32'(timeout_err), 1);
    check("to_send_cycles", 32'(sends), 12);
    check("to_link_req_low", 32'(link_req), 0);
    check("to_no_ans", 32'(ans_out), 0);
    @(negedge clk);
    check("to_regrant_req", 32'(link_req), 1);
    check("to_regrant_data", 32'(link_data), 32'h0C0C);
    check("to_err_pulse", 32'(timeout_err), 0);
    push_exp(DIR_R, 16'h0C0C);
    resp_en = 1'b1;
    wait_ans("to_retry_wait", 20);
    req_in = '0;
    @(negedge clk);
    check("to_count", 32'(n_timeouts), 1);

    // Winner changes data and drops req mid-SEND: packet stays committed
    ans_delay = 4;
    set_data(DIR_D, 16'hBEEF);
    req_in = 5'b01000;
    push_exp(DIR_D, 16'hBEEF);
    @(negedge clk);
    check("chg_link_data", 32'(link_data), 32'hBEEF);
    set_data(DIR_D, 16'h0BAD);
    req_in = '0;
    wait_ans("chg_wait", 15);
    @(negedge clk);
    check("chg_busy_low", 32'(busy), 0);

    // Reset mid-SEND: outputs clear at once, requester 0 wins afterwards
    resp_en = 1'b0;
    set_data(DIR_L, 16'h1111);
    req_in = 5'b00010;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_pre_req", 32'(link_req), 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_link_req", 32'(link_req), 0);
    check("mid_rst_link_en", 32'(link_en), 0);
    check("mid_rst_link_data", 32'(link_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    for (int i = 0; i < N; i++) set_data(i, 16'h2000 + 16'(i));
    req_in = '1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    push_exp(DIR_R, 16'h2000);
    ans_delay = 0;
    resp_en   = 1'b1;
    wait_ans("mid_rst_prio_wait", 10);
    req_in = '0;
    @(negedge clk);

`ifdef NOC_LINK_ARB_STATS_EN
    // Delivery counters: saturate at 255, timeouts not counted
    do_reset();
    for (int i = 0; i < N; i++) check("st_rst_cnt", 32'(grant_cnt[i*8 +: 8]), 0);
    set_data(DIR_LOCAL, 16'h4C4C);
    for (int k = 0; k < 300; k++) push_exp(DIR_LOCAL, 16'h4C4C);
    req_in = 5'b10000;
    for (int k = 0; k < 300; k++) wait_ans("st_wait", 10);
    req_in = '0;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      check("st_cnt", 32'(grant_cnt[i*8 +: 8]), (i == DIR_LOCAL) ? 255 : 0);
    resp_en = 1'b0;
    req_in  = 5'b00001;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (timeout_err) break;
    end
    check("st_to_seen", 32'(timeout_err), 1);
    req_in = '0;
    @(negedge clk);
    check("st_to_not_counted", 32'(grant_cnt[7:0]), 0);
`endif

    check("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
